zorro2_fastram_ctrl: RTL and testbench
======================================

Name: zorro2_fastram_ctrl

Overview:
Parametrised successor to the 8MB GottaGoFast FastRAM controller for Amiga 500/1000/2000 boards. It is fully synchronous to CLK and supports 1–4 DRAM blocks of 2MB each. Autoconfig offers the installed memory in the largest aligned chunks, chaining further offers with the "next board related" bit. A timer-driven CAS-before-RAS refresh engine holds a pending-request backlog, so refresh never collides with bus accesses. The block sits between the 68000 expansion bus and one DRAM array, and drives the CFGOUTn chain onward.

Parameters:
BLOCKS, 4, installed 2MB blocks (1..4)
MFG_ID, 16'h07DB, autoconfig manufacturer ID
PROD_ID, 8'd70, autoconfig product number
SERIAL, 32'd421, autoconfig serial number
REFRESH_DIV, 100, CLK cycles between refresh requests (must be ≥ 8)
TRP, 1, precharge cycles after any RAS deassertion (1..3)

Ports:
CLK  in  1  bus clock (7.09/7.16MHz)
RESETn  in  1  asynchronous active-low reset
CFGINn  in  1  autoconfig chain in, active low
CFGOUTn  out  1  autoconfig chain out, active low
ASn  in  1  address strobe
UDSn  in  1  upper data strobe
LDSn  in  1  lower data strobe
RWn  in  1  1 = read
ADDR  in  23  A23..A1
DBUS_IN  in  4  D15..D12 input
DBUS_OUT  out  4  autoconfig read nibble
DBUS_OE  out  1  tristate enable for D15..D12
MADDR  out  12  multiplexed DRAM address
RASn  out  1  DRAM RAS
UCASn  out  1  upper CAS
LCASn  out  1  lower CAS
OEn  out  1  data buffer enable, active low
MEMWn  out  1  DRAM write enable
CONFIGURED  out  1  at least one 1MB region mapped

Behaviour:
- Reset (async): CFGOUTn=1, RASn=UCASn=LCASn=OEn=MEMWn=1, DBUS_OE=0, DBUS_OUT=4'hF, MADDR=0, CONFIGURED=0. The map, offer state and refresh counter are cleared. Reset mid-cycle releases all DRAM strobes immediately. The bus inputs ASn, UDSn, LDSn and RWn are double-registered before use.
- Offer sequence: remaining=BLOCKS. Each offer is 4 blocks → 8MB (size 000), 2–3 → 4MB (111), 1 → 2MB (110).
- Per offer: reg $00 = 4'hE. Reg $02 = {more, size}, where more=1 if blocks remain after this offer. Regs $04/$06 = ~PROD_ID. Reg $08 = ~4'h8. Regs $10–$16 = ~MFG_ID. Regs $18–$1E = ~SERIAL[15:0]. Regs $40/$42 = 0. All other registers = 4'hF.
- Autoconfig active = ADDR[23:16]==E8 & CFGINn registered low & !done.
- DBUS_OE = active & !ASn & RWn & !UDSn, combinational from the synchronised strobes. DBUS_OUT is registered one CLK after the address is valid.
- Write to $48 (ADDR[8:1]==8'h24, sampled on the synchronised UDSn falling edge) captures base = DBUS_IN as A23..A20.
  - If base is in $2..$9 and aligned to the offer size (8MB requires base 2), the matching map bits for base..base+size-1 are set.
  - Otherwise nothing is mapped.
  - In both cases remaining is reduced by the offer size.
- Write to $4C (shutup) reduces remaining by the offer size and maps nothing.
- done=1 when remaining==0. CFGOUTn takes !done on the next synchronised ASn rising edge.
- CONFIGURED = |map.
- Hit = !ASn & map[ADDR[23:20]-2] & ADDR[23:20] in $2..$9.
- DRAM FSM states: IDLE, ROW, COL, CAS, PRE, RFC, RFR.
  - IDLE: MADDR=ADDR[22:11]. A hit goes to ROW, with priority over refresh.
  - ROW: RASn=0.
  - COL: MADDR={2'b00, ADDR[10:1]}.
  - CAS: UCASn/LCASn go low one CLK after the corresponding strobe is seen low. The FSM waits here until ASn is seen high, then goes to PRE.
  - PRE: all strobes high for TRP cycles, then IDLE.
- OEn = !(state in ROW..CAS) | ASn | (UDSn & LDSn).
- MEMWn = RWn | (UDSn & LDSn) | !(state in COL..CAS).
- Refresh: a counter reloads at REFRESH_DIV-1 and decrements every CLK. At 0, pending increments, saturating at 3.
  - In IDLE, with pending>0 and no hit: RFC (both CAS low, 1 CLK) → RFR (RAS+CAS low, 2 CLK) → PRE, then pending decrements.
  - A counter expiry on the same cycle as the decrement leaves pending unchanged.
  - A hit arriving during RFC or RFR waits until PRE completes.

Test Plan:
- BLOCKS=4, write $48 data 2 → map=8'hFF, CFGOUTn=0 after ASn rises; reg $02 had read 4'b0000.
- BLOCKS=3: first offer reads $02=4'b1111, written 2 → map=8'h0F; second offer reads 4'b0110, written 6 → map=8'h3F, done.
- BLOCKS=2: write $48 base 3 (misaligned 4MB) → map stays 0, CONFIGURED=0, done=1. Separately, shutup at $4C → CFGOUTn=0, no mapping.
- Mapped read at $200000 → RASn low 2 CLK after ASn sampled low, MADDR row then column, UCASn/LCASn low, all high TRP cycles after ASn high. Unmapped $A00000 → no strobes.
- Hold ASn low over 3·REFRESH_DIV cycles with continuous hits → pending saturates at 3; three back-to-back RFC/RFR sequences follow once the bus is idle.
- Assert RESETn low during CAS → all strobes high asynchronously, map cleared, CFGOUTn=1.

Source files
------------

// File: rtl/zorro2_fastram_ctrl.sv
// Zorro II FastRAM controller: autoconfig in chained power-of-two offers, DRAM
// access sequencing and a backlogged CAS-before-RAS refresh engine.
module zorro2_fastram_ctrl #(
  parameter int unsigned BLOCKS      = 4,
  parameter logic [15:0] MFG_ID      = 16'h07DB,
  parameter logic [7:0]  PROD_ID     = 8'd70,
  parameter logic [31:0] SERIAL      = 32'd421,
  parameter int unsigned REFRESH_DIV = 100,
  parameter int unsigned TRP         = 1
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        CFGINn,
  output logic        CFGOUTn,
  input  logic        ASn,
  input  logic        UDSn,
  input  logic        LDSn,
  input  logic        RWn,
  input  logic [23:1] ADDR,
  input  logic [3:0]  DBUS_IN,
  output logic [3:0]  DBUS_OUT,
  output logic        DBUS_OE,
  output logic [11:0] MADDR,
  output logic        RASn,
  output logic        UCASn,
  output logic        LCASn,
  output logic        OEn,
  output logic        MEMWn,
  output logic        CONFIGURED
);

  localparam int unsigned RW = $clog2(REFRESH_DIV);

  typedef enum logic [2:0] {
    S_IDLE, S_ROW, S_COL, S_CAS, S_PRE, S_RFC, S_RFR
  } state_t;

  state_t        state;
  logic [1:0]    as_sy, uds_sy, lds_sy, rw_sy;
  logic          as_s, uds_s, lds_s, rw_s;
  logic          as_d, uds_d, cfgin_r;
  logic [2:0]    remaining;
  logic [7:0]    map;
  logic [2:0]    offer_blk;
  logic [2:0]    size_code;
  logic [3:0]    offer_mb;
  logic          more, done, active, ac_wr;
  logic [3:0]    reg_nib;
  logic [3:0]    off;
  logic          base_ok;
  logic [7:0]    ones, mask;
  logic [3:0]    page;
  logic [2:0]    pidx;
  logic          hit;
  logic [RW-1:0] rcnt;
  logic          expire;
  logic [1:0]    pending;
  logic [1:0]    tcnt;
  logic          rf_done;

  assign as_s  = as_sy[1];
  assign uds_s = uds_sy[1];
  assign lds_s = lds_sy[1];
  assign rw_s  = rw_sy[1];

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      as_sy   <= '1;
      uds_sy  <= '1;
      lds_sy  <= '1;
      rw_sy   <= '1;
      as_d    <= 1'b1;
      uds_d   <= 1'b1;
      cfgin_r <= 1'b1;
    end else begin
      as_sy   <= {as_sy[0], ASn};
      uds_sy  <= {uds_sy[0], UDSn};
      lds_sy  <= {lds_sy[0], LDSn};
      rw_sy   <= {rw_sy[0], RWn};
      as_d    <= as_s;
      uds_d   <= uds_s;
      cfgin_r <= CFGINn;
    end
  end

  // Largest offer that fits what is left: 4 blocks (8MB), 2 blocks (4MB), 1 block (2MB).
  always_comb begin
    offer_blk = 3'd1;
    size_code = 3'b110;
    if (remaining >= 3'd4) begin
      offer_blk = 3'd4;
      size_code = 3'b000;
    end else if (remaining >= 3'd2) begin
      offer_blk = 3'd2;
      size_code = 3'b111;
    end
  end

  assign offer_mb = {offer_blk, 1'b0};
  assign more     = (remaining != offer_blk);
  assign done     = (remaining == 3'd0);
  assign active   = (ADDR[23:16] == 8'hE8) && !cfgin_r && !done;
  assign ac_wr    = active && !rw_s && uds_d && !uds_s;
  assign DBUS_OE  = active && !as_s && rw_s && !uds_s;

  // Alignment is measured from $2, the bottom of the FastRAM window.
  assign off     = DBUS_IN - 4'd2;
  assign base_ok = (DBUS_IN >= 4'd2) && (DBUS_IN <= 4'd9) &&
                   ((off & (offer_mb - 4'd1)) == 4'd0) &&
                   (({1'b0, off} + {1'b0, offer_mb}) <= 5'd8);
  assign ones    = 8'hFF >> (4'd8 - offer_mb);
  assign mask    = ones << off[2:0];

  always_comb begin
    reg_nib = 4'hF;
    case (ADDR[8:1])
      8'h00:        reg_nib = 4'hE;
      8'h01:        reg_nib = {more, size_code};
      8'h02:        reg_nib = ~PROD_ID[7:4];
      8'h03:        reg_nib = ~PROD_ID[3:0];
      8'h04:        reg_nib = ~4'h8;
      8'h08:        reg_nib = ~MFG_ID[15:12];
      8'h09:        reg_nib = ~MFG_ID[11:8];
      8'h0A:        reg_nib = ~MFG_ID[7:4];
      8'h0B:        reg_nib = ~MFG_ID[3:0];
      8'h0C:        reg_nib = ~SERIAL[15:12];
      8'h0D:        reg_nib = ~SERIAL[11:8];
      8'h0E:        reg_nib = ~SERIAL[7:4];
      8'h0F:        reg_nib = ~SERIAL[3:0];
      8'h20, 8'h21: reg_nib = 4'h0;
      default:      reg_nib = 4'hF;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      remaining <= 3'(BLOCKS);
      map       <= '0;
      CFGOUTn   <= 1'b1;
      DBUS_OUT  <= '1;
    end else begin
      DBUS_OUT <= active ? reg_nib : 4'hF;
      if (ac_wr && (ADDR[8:1] == 8'h24)) begin
        if (base_ok)
          map <= map | mask;
        remaining <= remaining - offer_blk;
      end else if (ac_wr && (ADDR[8:1] == 8'h26)) begin
        remaining <= remaining - offer_blk;
      end
      if (as_s && !as_d)
        CFGOUTn <= !done;
    end
  end

  assign CONFIGURED = |map;
  assign page       = ADDR[23:20];
  assign pidx       = 3'(page - 4'd2);
  assign hit        = !as_s && (page >= 4'd2) && (page <= 4'd9) && map[pidx];

  assign expire  = (rcnt == '0);
  assign rf_done = (state == S_RFR) && (tcnt == 2'd0);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      rcnt    <= RW'(REFRESH_DIV - 1);
      pending <= '0;
    end else begin
      rcnt <= expire ? RW'(REFRESH_DIV - 1) : rcnt - 1'b1;
      if (expire && !rf_done && (pending != 2'd3))
        pending <= pending + 2'd1;
      else if (!expire && rf_done)
        pending <= pending - 2'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state <= S_IDLE;
      RASn  <= 1'b1;
      UCASn <= 1'b1;
      LCASn <= 1'b1;
      MADDR <= '0;
      tcnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          MADDR <= ADDR[22:11];
          if (hit) begin
            state <= S_ROW;
            RASn  <= 1'b0;
          end else if (pending != 2'd0) begin
            state <= S_RFC;
            UCASn <= 1'b0;
            LCASn <= 1'b0;
          end
        end
        S_ROW: begin
          state <= S_COL;
          MADDR <= {2'b00, ADDR[10:1]};
        end
        S_COL: state <= S_CAS;
        S_CAS: begin
          if (as_s) begin
            state <= S_PRE;
            RASn  <= 1'b1;
            UCASn <= 1'b1;
            LCASn <= 1'b1;
            tcnt  <= 2'(TRP - 1);
          end else begin
            UCASn <= uds_s;
            LCASn <= lds_s;
          end
        end
        S_PRE: begin
          if (tcnt == 2'd0)
            state <= S_IDLE;
          else
            tcnt <= tcnt - 2'd1;
        end
        S_RFC: begin
          state <= S_RFR;
          RASn  <= 1'b0;
          tcnt  <= 2'd1;
        end
        S_RFR: begin
          if (tcnt == 2'd0) begin
            state <= S_PRE;
            RASn  <= 1'b1;
            UCASn <= 1'b1;
            LCASn <= 1'b1;
            tcnt  <= 2'(TRP - 1);
          end else begin
            tcnt <= tcnt - 2'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign OEn   = !((state == S_ROW) || (state == S_COL) || (state == S_CAS)) ||
                 as_s || (uds_s && lds_s);
  assign MEMWn = rw_s || (uds_s && lds_s) || !((state == S_COL) || (state == S_CAS));

endmodule

// File: tb/tb_zorro2_fastram_ctrl.sv
// Directed bench for zorro2_fastram_ctrl: three boards (4, 3 and 2 blocks) on a shared bus,
// each enabled in turn through its own CFGINn.
module tb_zorro2_fastram_ctrl;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic        ASn, UDSn, LDSn, RWn;
  logic [23:1] ADDR;
  logic [3:0]  DBUS_IN;
  logic        cfgin4, cfgin3, cfgin2;

  logic        cfgout4, cfgout3, cfgout2;
  logic [3:0]  dout4, dout3, dout2;
  logic        oe4, oe3, oe2;
  logic [11:0] maddr4, maddr3, maddr2;
  logic        ras4, ras3, ras2, ucas4, ucas3, ucas2, lcas4, lcas3, lcas2;
  logic        oen4, oen3, oen2, memw4, memw3, memw2, conf4, conf3, conf2;

  int          sel;
  logic [3:0]  dsel;
  logic        oesel;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 CLK = ~CLK;

  zorro2_fastram_ctrl #(.BLOCKS(4)) dut4 (
    .CLK(CLK), .RESETn(RESETn), .CFGINn(cfgin4), .CFGOUTn(cfgout4),
    .ASn(ASn), .UDSn(UDSn), .LDSn(LDSn), .RWn(RWn), .ADDR(ADDR), .DBUS_IN(DBUS_IN),
    .DBUS_OUT(dout4), .DBUS_OE(oe4), .MADDR(maddr4), .RASn(ras4), .UCASn(ucas4),
    .LCASn(lcas4), .OEn(oen4), .MEMWn(memw4), .CONFIGURED(conf4));

  zorro2_fastram_ctrl #(.BLOCKS(3)) dut3 (
    .CLK(CLK), .RESETn(RESETn), .CFGINn(cfgin3), .CFGOUTn(cfgout3),
    .ASn(ASn), .UDSn(UDSn), .LDSn(LDSn), .RWn(RWn), .ADDR(ADDR), .DBUS_IN(DBUS_IN),
    .DBUS_OUT(dout3), .DBUS_OE(oe3), .MADDR(maddr3), .RASn(ras3), .UCASn(ucas3),
    .LCASn(lcas3), .OEn(oen3), .MEMWn(memw3), .CONFIGURED(conf3));

  zorro2_fastram_ctrl #(.BLOCKS(2)) dut2 (
    .CLK(CLK), .RESETn(RESETn), .CFGINn(cfgin2), .CFGOUTn(cfgout2),
    .ASn(ASn), .UDSn(UDSn), .LDSn(LDSn), .RWn(RWn), .ADDR(ADDR), .DBUS_IN(DBUS_IN),
    .DBUS_OUT(dout2), .DBUS_OE(oe2), .MADDR(maddr2), .RASn(ras2), .UCASn(ucas2),
    .LCASn(lcas2), .OEn(oen2), .MEMWn(memw2), .CONFIGURED(conf2));

  always_comb begin
    dsel  = dout4;
    oesel = oe4;
    case (sel)
      3: begin dsel = dout3; oesel = oe3; end
      2: begin dsel = dout2; oesel = oe2; end
      default: begin dsel = dout4; oesel = oe4; end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_addr(input logic [23:0] a);
    ADDR = a[23:1];
  endtask

  task automatic bus_idle();
    ASn = 1'b1; UDSn = 1'b1; LDSn = 1'b1; RWn = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic cfg_read(input string tag, input logic [7:0] off, input logic [3:0] exp);
    set_addr({8'hE8, 8'h00, off});
    RWn = 1'b1; ASn = 1'b0; UDSn = 1'b0; LDSn = 1'b0;
    tick(); tick(); tick();
    check({tag, "_oe"}, oesel, 1);
    check(tag, dsel, exp);
    ASn = 1'b1; UDSn = 1'b1; LDSn = 1'b1;
    tick(); tick();
  endtask

  // Leaves ASn asserted so the caller can look at state before the strobe rises.
  task automatic cfg_write(input logic [7:0] off, input logic [3:0] d);
    set_addr({8'hE8, 8'h00, off});
    RWn = 1'b0; DBUS_IN = d; ASn = 1'b0; UDSn = 1'b1; LDSn = 1'b1;
    tick();
    UDSn = 1'b0;
    tick(); tick(); tick();
  endtask

  initial begin
    logic found;
    logic seen;
    int   cnt;

    RESETn = 1'b0; ASn = 1'b1; UDSn = 1'b1; LDSn = 1'b1; RWn = 1'b1;
    ADDR = '0; DBUS_IN = '0; cfgin4 = 1'b1; cfgin3 = 1'b1; cfgin2 = 1'b1; sel = 4;
    tick(); tick(); tick();
    check("rst_cfgout", cfgout4, 1);
    check("rst_strobes", {ras4, ucas4, lcas4, oen4, memw4}, 5'h1F);
    check("rst_dbus_oe", oe4, 0);
    check("rst_dbus_out", dout4, 4'hF);
    check("rst_maddr", maddr4, 0);
    check("rst_configured", conf4, 0);

    // Four-block board: one 8MB offer
    RESETn = 1'b1; cfgin4 = 1'b0;
    tick();
    cfg_read("b4_r00", 8'h00, 4'hE);
    cfg_read("b4_r02", 8'h02, 4'h0);
    cfg_read("b4_r04", 8'h04, 4'hB);
    cfg_read("b4_r06", 8'h06, 4'h9);
    cfg_read("b4_r08", 8'h08, 4'h7);
    cfg_read("b4_r10", 8'h10, 4'hF);
    cfg_read("b4_r12", 8'h12, 4'h8);
    cfg_read("b4_r1a", 8'h1A, 4'hE);
    cfg_read("b4_r1e", 8'h1E, 4'hA);
    cfg_read("b4_r40", 8'h40, 4'h0);
    cfg_read("b4_r20", 8'h20, 4'hF);
    cfg_write(8'h48, 4'h2);
    check("b4_map", dut4.map, 8'hFF);
    check("b4_cfgout_hold", cfgout4, 1);
    bus_idle();
    check("b4_cfgout", cfgout4, 0);
    check("b4_configured", conf4, 1);

    // Align to a refresh so the access below sees an idle engine
    found = 1'b0;
    for (int i = 0; i < 250 && !found; i++) begin
      tick();
      if (ucas4 == 1'b0 && ras4 == 1'b1) found = 1'b1;
    end
    check("rf_seen", found, 1);
    tick();
    check("rf_cbr", {ras4, ucas4, lcas4}, 3'b000);
    tick(); tick();
    check("rf_pre", {ras4, ucas4, lcas4}, 3'b111);
    tick();

    // Mapped read at $21F5A4: row $43E, column $2D2
    set_addr(24'h21F5A4);
    RWn = 1'b1; ASn = 1'b0; UDSn = 1'b0; LDSn = 1'b0;
    tick();
    check("rd_ras_p1", ras4, 1);
    tick();
    check("rd_ras_p2", ras4, 1);
    tick();
    check("rd_ras_p3", ras4, 0);
    check("rd_row", maddr4, 12'h43E);
    tick();
    check("rd_col", maddr4, 12'h2D2);
    check("rd_oen", oen4, 0);
    check("rd_memwn", memw4, 1);
    tick();
    check("rd_cas_wait", {ucas4, lcas4}, 2'b11);
    tick();
    check("rd_cas", {ucas4, lcas4}, 2'b00);
    ASn = 1'b1; UDSn = 1'b1; LDSn = 1'b1;
    tick(); tick();
    check("rd_hold", {ras4, ucas4, lcas4}, 3'b000);
    tick();
    check("rd_release", {ras4, ucas4, lcas4}, 3'b111);
    tick(); tick();

    // Unmapped $A00000
    set_addr(24'hA00000);
    ASn = 1'b0; UDSn = 1'b0; LDSn = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ras4 == 1'b0 || ucas4 == 1'b0) seen = 1'b1;
    end
    check("unmapped_strobe", seen, 0);
    bus_idle();

    // Long access at $300000 starves refresh long enough for at least four expiries
    set_addr(24'h300000);
    ASn = 1'b0; UDSn = 1'b0; LDSn = 1'b0;
    for (int i = 0; i < 420; i++) tick();
    check("hold_ras", ras4, 0);
    check("pend_sat", dut4.pending, 3);
    ASn = 1'b1; UDSn = 1'b1; LDSn = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (ucas4 == 1'b0 && ras4 == 1'b1) found = 1'b1;
    end
    check("bkl_start", found, 1);
    cnt = 1;
    for (int i = 1; i < 15; i++) begin
      tick();
      if (ucas4 == 1'b0 && ras4 == 1'b1) cnt++;
    end
    check("bkl_count", cnt, 3);
    tick(); tick(); tick(); tick(); tick(); tick();

    // Reset while the access sits in CAS
    set_addr(24'h21F5A4);
    RWn = 1'b1; ASn = 1'b0; UDSn = 1'b0; LDSn = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (ras4 == 1'b0 && ucas4 == 1'b0 && oen4 == 1'b0) found = 1'b1;
    end
    check("cas_reached", found, 1);
    #2 RESETn = 1'b0;
    #1;
    check("arst_strobes", {ras4, ucas4, lcas4, oen4, memw4}, 5'h1F);
    check("arst_cfgout", cfgout4, 1);
    check("arst_map", dut4.map, 0);
    check("arst_configured", conf4, 0);
    tick();
    ASn = 1'b1; UDSn = 1'b1; LDSn = 1'b1;
    RESETn = 1'b1;
    tick();

    // Three-block board: 4MB then 2MB
    cfgin4 = 1'b1; cfgin3 = 1'b0; sel = 3;
    tick();
    cfg_read("b3_r02a", 8'h02, 4'hF);
    cfg_write(8'h48, 4'h2);
    check("b3_map_a", dut3.map, 8'h0F);
    bus_idle();
    check("b3_cfgout_a", cfgout3, 1);
    cfg_read("b3_r02b", 8'h02, 4'h6);
    cfg_write(8'h48, 4'h6);
    check("b3_map_b", dut3.map, 8'h3F);
    bus_idle();
    check("b3_cfgout_b", cfgout3, 0);
    check("b3_configured", conf3, 1);

    // Two-block board: misaligned base, then shutup after reset
    cfgin3 = 1'b1; cfgin2 = 1'b0; sel = 2;
    tick();
    cfg_read("b2_r02", 8'h02, 4'h7);
    cfg_write(8'h48, 4'h3);
    check("b2_map_mis", dut2.map, 8'h00);
    bus_idle();
    check("b2_configured", conf2, 0);
    check("b2_cfgout_mis", cfgout2, 0);
    RESETn = 1'b0;
    tick();
    RESETn = 1'b1;
    tick();
    check("b2_rst_cfgout", cfgout2, 1);
    cfg_write(8'h4C, 4'h2);
    bus_idle();
    check("b2_shutup_cfgout", cfgout2, 0);
    check("b2_shutup_map", dut2.map, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
